scaled_window_gen: RTL and testbench
====================================

Name: scaled_window_gen

Overview:
- Runtime-scalable successor to the fixed-scale GBA window timing logic in the HDMI image generator.
- Takes the HDMI core's raster position (cx/cy) and generates:
  - the source-window draw flag
  - line-cache read address (curPxl) and nextLine/cacheUpdate requests
  - sub-pixel phases for the smoother and grid
- Integer scale is selectable at runtime, applied only at frame boundaries, with centring computed automatically.
- Replaces the hard-coded maxScaleCnt and read-ahead constant with parameters.

Parameters:
- SRC_W, 240, source image width in pixels.
- SRC_H, 160, source image height in lines.
- FRAME_W, 1280, active output width.
- FRAME_H, 720, active output height.
- MAX_SCALE, 6, largest encodable scale; the effective ceiling is min(MAX_SCALE, FRAME_W/SRC_W, FRAME_H/SRC_H).
- DEF_SCALE, 4, scale loaded at reset; clamped like requests.
- READ_LAT, 3, cycles from a curPxl change to the pixel reaching the output mux.

Ports:
- pxlClk  in  1  pixel clock
- rst  in  1  reset
- cx  in  12  HDMI raster x
- cy  in  11  HDMI raster y
- frameWidth  in  12  total raster width incl. blanking
- frameHeight  in  11  total raster height incl. blanking
- scaleReq  in  3  requested scale, 1..MAX_SCALE
- sameLine  in  1  line cache is not ready to advance
- scaleAct  out  3  scale currently in effect
- drawWin  out  1  output pixel lies inside the source window
- curPxl  out  8  line-cache read index
- pxlPhase  out  3  horizontal sub-pixel phase, 0..scale-1
- linePhase  out  3  vertical sub-pixel phase, 0..scale-1
- nextLine  out  1  one-cycle request to advance the source line
- cacheUpdate  out  1  one-cycle pulse at window right edge each raster line
- gridAct  out  1  grid line active (see Optional Feature)

Behaviour:
- Reset is rst, synchronous, active-high; clock is pxlClk.
- Reset values:
  - all pulses, phases, curPxl, drawWin and gridAct = 0
  - scaleAct = clamp(DEF_SCALE)
- Clamp rule: s=0 → 1; s>ceiling → ceiling; also reduce s until xStart(s) ≥ READ_LAT.
- Window geometry:
  - xStart = (FRAME_W − s·SRC_W)>>1; xStop = xStart + s·SRC_W.
  - yStart = (FRAME_H − s·SRC_H)>>1; yStop = yStart + s·SRC_H.
  - Register all four whenever scaleAct changes.
  - Products come from a package LUT indexed by s, not a runtime multiplier.
- Frame boundary is cx==frameWidth−1 && cy==frameHeight−1.
  - On that cycle, scaleAct ← clamp(scaleReq).
  - Requests at any other time are held off; only the value sampled at the boundary counts.
- drawWin: registered, 1-cycle latency; set when xStart≤cx<xStop && yStart≤cy<yStop.
- curPxl / read-ahead:
  - When cx ≤ xStart−READ_LAT or cx > xStop−READ_LAT: curPxl=0, internal x count=0.
  - Otherwise the x count increments; on reaching s−1 it wraps to 0 and curPxl increments, saturating at SRC_W−1.
- pxlPhase is the x count delayed READ_LAT−1 cycles, so pxlPhase=0 coincides with the first drawWin=1 cycle and every source-pixel boundary.
- linePhase, evaluated at cx==frameWidth−1:
  - last raster line → 0
  - else if linePhase==s−1 → 0
  - else if cy ≥ yStart → +1
- nextLine = registered (cx==xStop && cy≥yStart && linePhase==s−1 && !sameLine).
- cacheUpdate = registered (cx==xStop).
- Boundary conditions:
  - Scale change takes effect from the first line of the next frame; the old geometry completes the current frame unchanged.
  - rst mid-frame: counters zero immediately; drawWin stays low until cx/cy next enter the window.
  - cx values beyond frameWidth are tolerated; they simply never match.

Optional Feature:
- Macro: SCALED_WINDOW_GRID_EN.
- Defined: gridAct = registered (drawWin condition && (pxlPhase==0 || linePhase==0)), aligned with drawWin.
- Undefined: gridAct tied 0 and the grid logic is not synthesised.

Decomposition:
- Shared package holds:
  - SRC_W/SRC_H/FRAME_W/FRAME_H defaults
  - scale_t (logic [2:0])
  - span LUT functions srcSpanX(s), srcSpanY(s)
  - clampScale() function
- Sub-module scale_phase_counter: generic 0..s−1 wrap counter with enable, clear and carry-out. Instantiate it for the x count and for linePhase.

Test Plan:
- Defaults (1280×720, 240×160), scaleReq=3 held through reset and a frame boundary → scaleAct=3; drawWin high for cx 280..999, cy 120..599.
- scaleReq=5 → clamped: scaleAct=4, xStart=160, yStart=40, xStop=1120, yStop=680.
- Scale 4, line cy=40 → curPxl increments first at cx 157+4·k−1 boundaries; pxlPhase=0 at cx 160,164,…; curPxl saturates at 239.
- scaleReq toggled 4→2 mid-frame at cy=300 → geometry unchanged until the frame boundary; the next frame uses xStart=400, yStart=200.
- Scale 4, sameLine=1 on the 4th line of a group → no nextLine pulse; cacheUpdate still pulses at cx=1120.
- rst asserted at cx=500, cy=300 for one cycle → all outputs 0 next cycle; drawWin recovers at the next window line with pxlPhase aligned.

Source files
------------

// File: rtl/scaled_window_gen_pkg.sv
// Shared scale type, default raster geometry and scale helpers for scaled_window_gen.
package scaled_window_gen_pkg;

   typedef logic [2:0] scale_t;

   typedef struct packed {
      logic [11:0] x_start;
      logic [11:0] x_stop;
      logic [11:0] rd_lo;
      logic [11:0] rd_hi;
      logic [10:0] y_start;
      logic [10:0] y_stop;
   } win_geom_t;

   localparam int SRC_W_DEF   = 240;
   localparam int SRC_H_DEF   = 160;
   localparam int FRAME_W_DEF = 1280;
   localparam int FRAME_H_DEF = 720;

   // With w fixed at elaboration every arm folds to a literal, so no multiplier is built.
   function automatic int spanLut(input scale_t s, input int w);
      int span;
      case (s)
         3'd1:    span = w;
         3'd2:    span = 2 * w;
         3'd3:    span = 3 * w;
         3'd4:    span = 4 * w;
         3'd5:    span = 5 * w;
         3'd6:    span = 6 * w;
         3'd7:    span = 7 * w;
         default: span = 0;
      endcase
      return span;
   endfunction

   function automatic int srcSpanX(input scale_t s, input int srcW);
      return spanLut(s, srcW);
   endfunction

   function automatic int srcSpanY(input scale_t s, input int srcH);
      return spanLut(s, srcH);
   endfunction

   function automatic scale_t clampScale(input scale_t req, input int srcW, input int srcH,
                                         input int frmW, input int frmH, input int maxS,
                                         input int readLat);
      int ceilS;
      int s;
      ceilS = maxS;
      if (frmW / srcW < ceilS) ceilS = frmW / srcW;
      if (frmH / srcH < ceilS) ceilS = frmH / srcH;
      if (ceilS > 7) ceilS = 7;
      if (ceilS < 1) ceilS = 1;
      s = (req == 3'd0) ? 1 : int'(req);
      if (s > ceilS) s = ceilS;
      // The read-ahead needs READ_LAT cycles of left margin before the window opens.
      for (int i = 0; i < 7; i++) begin
         if (s > 1 && (frmW - srcSpanX(s[2:0], srcW)) / 2 < readLat) s = s - 1;
      end
      return s[2:0];
   endfunction

endpackage

// File: rtl/scale_phase_counter.sv
// Wrapping 0..scale-1 phase counter; carry flags the terminal count so the next stage can advance.
module scale_phase_counter
   import scaled_window_gen_pkg::*;
(
   input  logic   pxlClk,
   input  logic   rst,
   input  scale_t scale,
   input  logic   en,
   input  logic   clr,
   output scale_t cnt,
   output logic   carry
);

   assign carry = (cnt == scale - 3'd1);

   always_ff @(posedge pxlClk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en)
         cnt <= carry ? '0 : cnt + 3'd1;
   end

endmodule

// File: rtl/scaled_window_gen.sv
// Runtime-scalable, auto-centred source window timing for the HDMI image generator.
// Optional grid overlay output is built only when SCALED_WINDOW_GRID_EN is defined.
module scaled_window_gen
   import scaled_window_gen_pkg::*;
#(
   parameter int SRC_W     = SRC_W_DEF,
   parameter int SRC_H     = SRC_H_DEF,
   parameter int FRAME_W   = FRAME_W_DEF,
   parameter int FRAME_H   = FRAME_H_DEF,
   parameter int MAX_SCALE = 6,
   parameter int DEF_SCALE = 4,
   parameter int READ_LAT  = 3
) (
   input  logic        pxlClk,
   input  logic        rst,
   input  logic [11:0] cx,
   input  logic [10:0] cy,
   input  logic [11:0] frameWidth,
   input  logic [10:0] frameHeight,
   input  logic [2:0]  scaleReq,
   input  logic        sameLine,
   output logic [2:0]  scaleAct,
   output logic        drawWin,
   output logic [7:0]  curPxl,
   output logic [2:0]  pxlPhase,
   output logic [2:0]  linePhase,
   output logic        nextLine,
   output logic        cacheUpdate,
   output logic        gridAct
);

   localparam scale_t     RESET_SCALE = clampScale(scale_t'(DEF_SCALE), SRC_W, SRC_H,
                                                   FRAME_W, FRAME_H, MAX_SCALE, READ_LAT);
   localparam logic [7:0] PXL_LAST    = 8'(SRC_W - 1);

   function automatic win_geom_t geomOf(input scale_t s);
      win_geom_t g;
      int xs;
      int ys;
      xs = (FRAME_W - srcSpanX(s, SRC_W)) / 2;
      ys = (FRAME_H - srcSpanY(s, SRC_H)) / 2;
      g.x_start = 12'(xs);
      g.x_stop  = 12'(xs + srcSpanX(s, SRC_W));
      g.rd_lo   = 12'(xs - READ_LAT);
      g.rd_hi   = 12'(xs + srcSpanX(s, SRC_W) - READ_LAT);
      g.y_start = 11'(ys);
      g.y_stop  = 11'(ys + srcSpanY(s, SRC_H));
      return g;
   endfunction

   scale_t     scale_act;
   scale_t     scale_next;
   win_geom_t  geom;
   scale_t     x_count;
   logic       x_carry;
   logic       lp_carry;
   logic       armed;
   logic [2:0] phase_pipe [READ_LAT];

   logic frame_end;
   logic line_end;
   logic in_win;
   logic win_start;
   logic draw_cond;
   logic rd_en;
   logic at_x_stop;

   assign line_end  = (cx == frameWidth - 12'd1);
   assign frame_end = line_end && (cy == frameHeight - 11'd1);
   assign in_win    = (cx >= geom.x_start) && (cx < geom.x_stop) &&
                      (cy >= geom.y_start) && (cy < geom.y_stop);
   assign win_start = in_win && (cx == geom.x_start);
   assign draw_cond = in_win && (armed || win_start);
   assign rd_en     = (cx > geom.rd_lo) && (cx <= geom.rd_hi);
   assign at_x_stop = (cx == geom.x_stop);
   assign scaleAct  = scale_act;
   assign pxlPhase  = phase_pipe[READ_LAT-1];

   // New scale is sampled only at the frame boundary; geometry is registered alongside it.
   always_comb begin
      scale_next = scale_act;
      if (rst)
         scale_next = RESET_SCALE;
      else if (frame_end)
         scale_next = clampScale(scaleReq, SRC_W, SRC_H, FRAME_W, FRAME_H, MAX_SCALE, READ_LAT);
   end

   always_ff @(posedge pxlClk) begin
      scale_act <= scale_next;
      geom      <= geomOf(scale_next);
   end

   scale_phase_counter u_x_count (
      .pxlClk (pxlClk),
      .rst    (rst),
      .scale  (scale_act),
      .en     (rd_en),
      .clr    (!rd_en),
      .cnt    (x_count),
      .carry  (x_carry)
   );

   scale_phase_counter u_line_count (
      .pxlClk (pxlClk),
      .rst    (rst),
      .scale  (scale_act),
      .en     (line_end && ((cy >= geom.y_start) || lp_carry)),
      .clr    (frame_end),
      .cnt    (linePhase),
      .carry  (lp_carry)
   );

   always_ff @(posedge pxlClk) begin
      if (rst || !rd_en)
         curPxl <= '0;
      else if (x_carry && curPxl != PXL_LAST)
         curPxl <= curPxl + 8'd1;
   end

   // Phase rides the same latency as the cache read so phase 0 meets each new source pixel.
   always_ff @(posedge pxlClk) begin
      if (rst) begin
         for (int i = 0; i < READ_LAT; i++) phase_pipe[i] <= '0;
      end else begin
         phase_pipe[0] <= x_count;
         for (int i = 1; i < READ_LAT; i++) phase_pipe[i] <= phase_pipe[i-1];
      end
   end

   // After a reset the window is suppressed until a line is entered at its left edge.
   always_ff @(posedge pxlClk) begin
      if (rst) begin
         armed       <= 1'b0;
         drawWin     <= 1'b0;
         nextLine    <= 1'b0;
         cacheUpdate <= 1'b0;
      end else begin
         if (win_start) armed <= 1'b1;
         drawWin     <= draw_cond;
         cacheUpdate <= at_x_stop;
         nextLine    <= at_x_stop && (cy >= geom.y_start) && lp_carry && !sameLine;
      end
   end

`ifdef SCALED_WINDOW_GRID_EN
   always_ff @(posedge pxlClk) begin
      if (rst)
         gridAct <= 1'b0;
      else
         gridAct <= draw_cond && ((phase_pipe[READ_LAT-2] == 3'd0) || (linePhase == 3'd0));
   end
`else
   assign gridAct = 1'b0;
`endif

endmodule

// File: tb/tb_scaled_window_gen.sv
// Directed bench for scaled_window_gen: jumps the raster position to hand-picked points and sweeps key lines.
module tb_scaled_window_gen;

   logic        pxlClk = 1'b0;
   logic        rst;
   logic [11:0] cx;
   logic [10:0] cy;
   logic [11:0] frameWidth;
   logic [10:0] frameHeight;
   logic [2:0]  scaleReq;
   logic        sameLine;
   logic [2:0]  scaleAct;
   logic        drawWin;
   logic [7:0]  curPxl;
   logic [2:0]  pxlPhase;
   logic [2:0]  linePhase;
   logic        nextLine;
   logic        cacheUpdate;
   logic        gridAct;

   int checks = 0;
   int errors = 0;

   logic [15:0] dwExp;
   logic [15:0] ppExp;
   logic [15:0] cpExp;
   logic [15:0] gridExp;

   scaled_window_gen dut (
      .pxlClk      (pxlClk),
      .rst         (rst),
      .cx          (cx),
      .cy          (cy),
      .frameWidth  (frameWidth),
      .frameHeight (frameHeight),
      .scaleReq    (scaleReq),
      .sameLine    (sameLine),
      .scaleAct    (scaleAct),
      .drawWin     (drawWin),
      .curPxl      (curPxl),
      .pxlPhase    (pxlPhase),
      .linePhase   (linePhase),
      .nextLine    (nextLine),
      .cacheUpdate (cacheUpdate),
      .gridAct     (gridAct)
   );

   always #5 pxlClk = ~pxlClk;

   // One raster position per clock; outputs are sampled 1 time unit after the edge.
   task automatic applyStimulus(input int x, input int y);
      cx = 12'(x);
      cy = 11'(y);
      @(posedge pxlClk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkWin(input int x, input int y, input int expected);
      applyStimulus(x, y);
      checkOutput($sformatf("drawWin@%0d,%0d", x, y), 16'(drawWin), 16'(expected));
   endtask

   // Closed-form expectations for a scale-4 line (xStart 160, xStop 1120, read-ahead 3).
   task automatic sweepLine(input int y, input int first, input int last, input int checkFrom);
      for (int c = first; c <= last; c++) begin
         applyStimulus(c, y);
         if (c >= checkFrom) begin
            dwExp = 16'(c >= 160 && c < 1120);
            ppExp = (c >= 160 && c <= 1120) ? 16'((c - 160) % 4) : 16'd0;
            cpExp = (c >= 158 && c <= 1117) ?
                    16'((((c - 157) / 4) > 239) ? 239 : ((c - 157) / 4)) : 16'd0;
`ifdef SCALED_WINDOW_GRID_EN
            gridExp = dwExp;
`else
            gridExp = 16'd0;
`endif
            checkOutput($sformatf("sweep drawWin cx=%0d", c), 16'(drawWin), dwExp);
            checkOutput($sformatf("sweep pxlPhase cx=%0d", c), 16'(pxlPhase), ppExp);
            checkOutput($sformatf("sweep curPxl cx=%0d", c), 16'(curPxl), cpExp);
            checkOutput($sformatf("sweep cacheUpdate cx=%0d", c), 16'(cacheUpdate), 16'(c == 1120));
            checkOutput($sformatf("sweep nextLine cx=%0d", c), 16'(nextLine), 16'd0);
            checkOutput($sformatf("sweep gridAct cx=%0d", c), 16'(gridAct), gridExp);
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " drawWin"}, 16'(drawWin), 16'd0);
      checkOutput({tag, " curPxl"}, 16'(curPxl), 16'd0);
      checkOutput({tag, " pxlPhase"}, 16'(pxlPhase), 16'd0);
      checkOutput({tag, " linePhase"}, 16'(linePhase), 16'd0);
      checkOutput({tag, " nextLine"}, 16'(nextLine), 16'd0);
      checkOutput({tag, " cacheUpdate"}, 16'(cacheUpdate), 16'd0);
      checkOutput({tag, " gridAct"}, 16'(gridAct), 16'd0);
   endtask

   initial begin
      rst         = 1'b1;
      frameWidth  = 12'd1650;
      frameHeight = 11'd750;
      scaleReq    = 3'd3;
      sameLine    = 1'b0;

      // Reset: scale falls back to the clamped default of 4.
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      checkOutput("reset scaleAct", 16'(scaleAct), 16'd4);
      checkAllZero("reset");
      rst = 1'b0;

      // Scale 3 taken at the frame boundary: window 280..999 x 120..599.
      applyStimulus(1649, 749);
      checkOutput("s3 scaleAct", 16'(scaleAct), 16'd3);
      checkWin(279, 120, 0);
      checkWin(280, 120, 1);
      checkWin(999, 120, 1);
      checkWin(1000, 120, 0);
      checkOutput("s3 cacheUpdate at xStop", 16'(cacheUpdate), 16'd1);
      checkOutput("s3 nextLine phase0", 16'(nextLine), 16'd0);
      checkWin(280, 119, 0);
      checkWin(500, 599, 1);
      checkWin(500, 600, 0);
      checkOutput("s3 cacheUpdate off", 16'(cacheUpdate), 16'd0);

      // Request 5 clamps to 4: window 160..1119 x 40..679.
      scaleReq = 3'd5;
      applyStimulus(1649, 749);
      checkOutput("clamp scaleAct", 16'(scaleAct), 16'd4);
      checkOutput("clamp linePhase", 16'(linePhase), 16'd0);
      checkWin(159, 40, 0);
      checkWin(160, 40, 1);
      checkWin(1119, 40, 1);
      checkWin(1120, 40, 0);
      checkWin(500, 39, 0);
      checkWin(500, 679, 1);
      checkWin(500, 680, 0);

      // Full line at scale 4: read-ahead, phases and saturation.
      sweepLine(40, 140, 1125, 150);

      // Line phase and nextLine gating.
      applyStimulus(1649, 39);
      checkOutput("lp above window", 16'(linePhase), 16'd0);
      applyStimulus(1649, 40);
      checkOutput("lp line40", 16'(linePhase), 16'd1);
      applyStimulus(1649, 41);
      checkOutput("lp line41", 16'(linePhase), 16'd2);
      applyStimulus(1649, 42);
      checkOutput("lp line42", 16'(linePhase), 16'd3);
      sameLine = 1'b1;
      applyStimulus(1120, 43);
      checkOutput("sameLine nextLine", 16'(nextLine), 16'd0);
      checkOutput("sameLine cacheUpdate", 16'(cacheUpdate), 16'd1);
      sameLine = 1'b0;
      applyStimulus(1120, 43);
      checkOutput("nextLine pulse", 16'(nextLine), 16'd1);
      applyStimulus(1121, 43);
      checkOutput("nextLine end", 16'(nextLine), 16'd0);
      checkOutput("cacheUpdate end", 16'(cacheUpdate), 16'd0);
      applyStimulus(1649, 43);
      checkOutput("lp wrap", 16'(linePhase), 16'd0);
      applyStimulus(1649, 44);
      checkOutput("lp line44", 16'(linePhase), 16'd1);
      applyStimulus(1649, 749);
      checkOutput("lp last line", 16'(linePhase), 16'd0);
      checkOutput("s4 kept", 16'(scaleAct), 16'd4);

      // Mid-frame request for 2 is held off until the boundary.
      scaleReq = 3'd2;
      applyStimulus(500, 300);
      checkOutput("held scaleAct", 16'(scaleAct), 16'd4);
      checkWin(159, 300, 0);
      checkWin(160, 300, 1);
      applyStimulus(1649, 300);
      checkOutput("held at line end", 16'(scaleAct), 16'd4);
      applyStimulus(1649, 749);
      checkOutput("s2 scaleAct", 16'(scaleAct), 16'd2);
      scaleReq = 3'd4;
      checkWin(399, 200, 0);
      checkWin(400, 200, 1);
      checkWin(500, 199, 0);
      checkWin(879, 519, 1);
      checkWin(880, 300, 0);
      checkOutput("s2 cacheUpdate", 16'(cacheUpdate), 16'd1);
      checkWin(500, 520, 0);
      checkOutput("s2 still held", 16'(scaleAct), 16'd2);

      // Mid-frame reset at scale 4.
      applyStimulus(1649, 749);
      checkOutput("s4 again", 16'(scaleAct), 16'd4);
      sweepLine(300, 140, 500, 490);
      rst = 1'b1;
      applyStimulus(500, 300);
      rst = 1'b0;
      checkOutput("midrst scaleAct", 16'(scaleAct), 16'd4);
      checkAllZero("midrst");
      applyStimulus(501, 300);
      checkOutput("post rst drawWin", 16'(drawWin), 16'd0);
      checkOutput("post rst curPxl", 16'(curPxl), 16'd0);
      applyStimulus(502, 300);
      checkOutput("post rst drawWin 2", 16'(drawWin), 16'd0);
      sweepLine(301, 140, 200, 150);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
